// File: rtl/hlsm_sched5.sv
// Six-state scheduled datapath: three operations through one shared adder/subtractor,
// a compare/select step and a final shift step that publishes x/z with a one-cycle done pulse.
module hlsm_sched5 #(
    parameter int DATAWIDTH = 64,
    parameter int OUTWIDTH  = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_i,
    input  logic [DATAWIDTH-1:0] a_i,
    input  logic [DATAWIDTH-1:0] b_i,
    input  logic [DATAWIDTH-1:0] c_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [OUTWIDTH-1:0]  x_o,
    output logic [OUTWIDTH-1:0]  z_o
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADD1  = 3'd1,
        ADD2  = 3'd2,
        SUB   = 3'd3,
        CMP   = 3'd4,
        SHIFT = 3'd5
    } state_t;

    state_t                state_q;
    logic [DATAWIDTH-1:0]  a_q, b_q, c_q;
    logic [DATAWIDTH-1:0]  d_q, e_q, f_q;
    logic [DATAWIDTH-1:0]  g_q, h_q;
    logic                  lt_q, eq_q;
    logic                  busy_q, done_q;
    logic [OUTWIDTH-1:0]   x_q, z_q;

    // Shared adder/subtractor: subtraction is a + ~b + 1 on the same carry chain.
    logic [DATAWIDTH-1:0]  add_rhs;
    logic                  add_sub;
    logic [DATAWIDTH-1:0]  add_res;

    always_comb begin
        add_rhs = b_q;
        add_sub = 1'b0;
        case (state_q)
            ADD2:    add_rhs = c_q;
            SUB:     add_sub = 1'b1;
            default: ;
        endcase
    end

    assign add_res = a_q + (add_rhs ^ {DATAWIDTH{add_sub}})
                   + {{(DATAWIDTH-1){1'b0}}, add_sub};

    logic                  lt_w, eq_w;
    logic [DATAWIDTH-1:0]  g_w, h_w;

    assign lt_w = (d_q < e_q);
    assign eq_w = (d_q == e_q);
    assign g_w  = lt_w ? d_q : e_q;
    assign h_w  = eq_w ? g_w : f_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            d_q     <= '0;
            e_q     <= '0;
            f_q     <= '0;
            g_q     <= '0;
            h_q     <= '0;
            lt_q    <= 1'b0;
            eq_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            x_q     <= '0;
            z_q     <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        a_q     <= a_i;
                        b_q     <= b_i;
                        c_q     <= c_i;
                        busy_q  <= 1'b1;
                        state_q <= ADD1;
                    end
                end
                ADD1: begin
                    d_q     <= add_res;
                    state_q <= ADD2;
                end
                ADD2: begin
                    e_q     <= add_res;
                    state_q <= SUB;
                end
                SUB: begin
                    f_q     <= add_res;
                    state_q <= CMP;
                end
                CMP: begin
                    lt_q    <= lt_w;
                    eq_q    <= eq_w;
                    g_q     <= g_w;
                    h_q     <= h_w;
                    state_q <= SHIFT;
                end
                SHIFT: begin
                    // Shift at full width first so the bit crossing into the result window is kept.
                    x_q     <= OUTWIDTH'(h_q << lt_q);
                    z_q     <= OUTWIDTH'(g_q >> eq_q);
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign x_o    = x_q;
    assign z_o    = z_q;

endmodule

// File: doc/hlsm_sched5.md
HLSM_SCHED5 -- requirements
Module: hlsm_sched5

Interface
REQ-001 Parameter DATAWIDTH, default 64, SHALL set the operand and internal datapath width.
REQ-002 Parameter OUTWIDTH, default 32, SHALL set the x/z result width; OUTWIDTH <= DATAWIDTH.
REQ-003 clk  input  1  SHALL be the single clock; all state changes occur on its rising edge.
REQ-004 rst  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 start  input  1  SHALL request one computation; sampled only in IDLE.
REQ-006 a, b, c  input  DATAWIDTH each  SHALL be the operands, captured on the accepted start edge.
REQ-007 busy  output  1  SHALL be high in every state except IDLE.
REQ-008 done  output  1  SHALL pulse high for exactly one cycle when new x/z values are valid.
REQ-009 x, z  output  OUTWIDTH each  SHALL be the results; they hold their value until the next completion.

Function
REQ-010 The block SHALL compute the sequence d=a+b, e=a+c, f=a-b, dEQe=(d==e), dLTe=(d<e), g=dLTe?d:e, h=dEQe?g:f, greg=g, hreg=h, x=(hreg<<dLTe)[OUTWIDTH-1:0], z=(greg>>dEQe)[OUTWIDTH-1:0].
REQ-011 Add and subtract operations SHALL share one DATAWIDTH adder/subtractor, limited to one operation per cycle.
REQ-012 All arithmetic SHALL be unsigned, modulo 2^DATAWIDTH, with carry/borrow discarded.
REQ-013 Comparisons SHALL be unsigned.
REQ-014 Shifts SHALL be logical and zero-filling.
REQ-015 The FSM SHALL have the states IDLE, ADD1, ADD2, SUB, CMP and SHIFT.
REQ-016 IDLE: when start=1, the block SHALL latch a, b, c into operand registers and go to ADD1; otherwise it stays in IDLE.
REQ-017 ADD1 SHALL set d_r <= a+b, then go to ADD2.
REQ-018 ADD2 SHALL set e_r <= a+c, then go to SUB.
REQ-019 SUB SHALL set f_r <= a-b, then go to CMP.
REQ-020 CMP SHALL register dLTe and dEQe, load greg <= g and hreg <= h, then go to SHIFT.
REQ-021 SHIFT SHALL load x and z from greg/hreg and the registered flags, set done <= 1 and go to IDLE.
REQ-022 Latency: with start accepted at edge N, done and the new x/z SHALL be visible after edge N+5 (6-cycle issue interval minimum).
REQ-023 start asserted while busy=1 SHALL be ignored, with no queuing and no operand recapture.
REQ-024 start asserted in the IDLE cycle where done=1 SHALL be accepted, giving back-to-back operation.
REQ-025 Operand input changes after capture SHALL NOT affect the result in flight.
REQ-026 done SHALL never be high for two consecutive cycles.
REQ-027 done and busy SHALL never be high in the same cycle.
REQ-028 x and z SHALL change only on the edge that raises done.

Reset
REQ-029 rst=0 SHALL immediately force the state to IDLE and clear busy, done, x, z, greg, hreg, the flags and all intermediate registers to 0.
REQ-030 Reset asserted mid-operation SHALL abort the operation: no done pulse, x/z = 0.
REQ-031 After rst returns high, the first start SHALL be accepted normally.

Verification
REQ-032 a=5, b=3, c=10, start -> d=8, e=15, f=2, lt=1, eq=0, g=8, h=2; done after 5 edges; x=4, z=8.
REQ-033 a=1, b=2, c=2 -> d=e=3, eq=1, lt=0, g=3, h=3; x=3, z=1.
REQ-034 a=0xFFFF_FFFF_FFFF_FFFF, b=1, c=0 -> d=0, e=a, f=0xFFFF_FFFF_FFFF_FFFE, lt=1; g=0, h=f; x=0xFFFF_FFFC, z=0.
REQ-035 start held high from the accept cycle through SHIFT, with a, b, c changed each cycle -> exactly one done; result matches the captured operands; a second run starts on the done cycle and completes 6 cycles after the first done.
REQ-036 rst pulsed low during CMP of the REQ-032 run -> busy=0 and x=z=0 at once; no done; a subsequent REQ-033 run gives x=3, z=1.
